// File: rtl/gig_basex_tx_encoder_pkg.sv
// rtl/gig_basex_tx_encoder_pkg.sv - 1000BASE-X code-group constants, GMII bus and TX encoder state types
//
// Shared by the PCS TX encoder and the PCS RX decode.
// Holds the 8b/10b code-group byte values, the GMII bus struct and the TX ordered-set state enum.
package gig_basex_tx_encoder_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;  // comma, idle even slot
  localparam logic [7:0] D16_2 = 8'h50;  // /I2/ odd slot
  localparam logic [7:0] D21_5 = 8'hB5;  // /C1/ config
  localparam logic [7:0] D2_2  = 8'h42;  // /C2/ config
  localparam logic [7:0] K27_7 = 8'hFB;  // /S/ start of packet
  localparam logic [7:0] K29_7 = 8'hFD;  // /T/ end of packet
  localparam logic [7:0] K23_7 = 8'hF7;  // /R/ carrier extend
  localparam logic [7:0] K30_7 = 8'hFE;  // /V/ error propagation

  typedef struct packed {
    logic       dvalid;
    logic       en;
    logic       er;
    logic [7:0] data;
  } GmiiBus;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_END_T,
    ST_END_R,
    ST_END_R2,
    ST_DISCARD
  } tx_state_e;

endpackage

// File: rtl/gig_basex_tx_encoder.sv
// rtl/gig_basex_tx_encoder.sv - GMII TX to 1000BASE-X ordered-set encoder (idle, /S/, data, /V/, /T/R/)
//
// Ports:
//   clk_125mhz                  in   PCS TX clock
//   rst                         in   synchronous active-high reset
//   link_up                     in   PCS link status, gates new frame starts
//   gmii_tx_bus                 in   MAC TX bus (en, er, data used; dvalid ignored)
//   tx_data_is_ctl              out  current code-group is a K character
//   tx_data                     out  code-group byte
//   tx_force_disparity_negative out  force negative running disparity (idle K28.5 only)
//   tx_frame_active             out  high from /S/ through the last data byte or /V/
//   tx_frame_dropped            out  one-cycle pulse when a frame start is discarded
module gig_basex_tx_encoder
  import gig_basex_tx_encoder_pkg::*;
(
  input  logic       clk_125mhz,
  input  logic       rst,
  input  logic       link_up,
  input  GmiiBus     gmii_tx_bus,
  output logic       tx_data_is_ctl,
  output logic [7:0] tx_data,
  output logic       tx_force_disparity_negative,
  output logic       tx_frame_active,
  output logic       tx_frame_dropped
);

  // state_q names what the registered outputs currently show; even_q is the
  // parity of that output slot. Everything below computes the next slot.
  tx_state_e  state_q, state_d;
  logic       even_q, even_d;
  logic [7:0] data_q, data_d;
  logic       ctl_q, ctl_d;
  logic       fneg_q, fneg_d;
  logic       active_q, active_d;
  logic       dropped_q, dropped_d;
  // Remembers that the pulse was already given for a start seen during /T/R/.
  logic       drop_seen_q, drop_seen_d;

  logic unused_dvalid;
  assign unused_dvalid = gmii_tx_bus.dvalid;

  always_comb begin
    even_d      = ~even_q;
    state_d     = state_q;
    // Default: idle code-group matching the parity of the next slot.
    data_d      = even_d ? K28_5 : D16_2;
    ctl_d       = even_d;
    fneg_d      = even_d;
    active_d    = 1'b0;
    dropped_d   = 1'b0;
    drop_seen_d = drop_seen_q;

    case (state_q)
      ST_DATA: begin
        fneg_d = 1'b0;
        if (!gmii_tx_bus.en) begin
          // er without en (carrier extension) is treated as end of frame.
          data_d  = K29_7;
          ctl_d   = 1'b1;
          state_d = ST_END_T;
        end else begin
          active_d = 1'b1;
          if (gmii_tx_bus.er) begin
            data_d = K30_7;
            ctl_d  = 1'b1;
          end else begin
            data_d = gmii_tx_bus.data;
            ctl_d  = 1'b0;
          end
        end
      end
      ST_END_T: begin
        data_d  = K23_7;
        ctl_d   = 1'b1;
        fneg_d  = 1'b0;
        state_d = ST_END_R;
      end
      ST_END_R: begin
        if (!even_d) begin
          // Second /R/ so that idle resumes on an even slot.
          data_d  = K23_7;
          ctl_d   = 1'b1;
          fneg_d  = 1'b0;
          state_d = ST_END_R2;
        end else begin
          state_d = gmii_tx_bus.en ? ST_DISCARD : ST_IDLE;
        end
      end
      ST_END_R2: begin
        state_d = gmii_tx_bus.en ? ST_DISCARD : ST_IDLE;
      end
      ST_DISCARD: begin
        if (!gmii_tx_bus.en) state_d = ST_IDLE;
      end
      default: begin  // ST_IDLE
        if (gmii_tx_bus.en) begin
          if (!link_up) begin
            dropped_d = 1'b1;
            state_d   = ST_DISCARD;
          end else if (even_d) begin
            data_d   = K27_7;
            ctl_d    = 1'b1;
            fneg_d   = 1'b0;
            active_d = 1'b1;
            state_d  = ST_DATA;
          end
          // Odd slot: this byte is lost under the idle D16.2 and /S/ replaces
          // the next byte, which lands on an even slot.
        end
      end
    endcase

    // A start during /T/R/ is dropped, but the end sequence still completes
    // so the previous frame is terminated cleanly.
    if ((state_q == ST_END_T) || (state_q == ST_END_R) || (state_q == ST_END_R2)) begin
      if (gmii_tx_bus.en && !drop_seen_q) begin
        dropped_d   = 1'b1;
        drop_seen_d = 1'b1;
      end
    end
    if ((state_d == ST_IDLE) || (state_d == ST_DISCARD)) drop_seen_d = 1'b0;
  end

  always_ff @(posedge clk_125mhz) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      even_q      <= 1'b1;
      data_q      <= K28_5;
      ctl_q       <= 1'b1;
      fneg_q      <= 1'b1;
      active_q    <= 1'b0;
      dropped_q   <= 1'b0;
      drop_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      even_q      <= even_d;
      data_q      <= data_d;
      ctl_q       <= ctl_d;
      fneg_q      <= fneg_d;
      active_q    <= active_d;
      dropped_q   <= dropped_d;
      drop_seen_q <= drop_seen_d;
    end
  end

  assign tx_data                     = data_q;
  assign tx_data_is_ctl              = ctl_q;
  assign tx_force_disparity_negative = fneg_q;
  assign tx_frame_active             = active_q;
  assign tx_frame_dropped            = dropped_q;

endmodule

// File: tb/tb_gig_basex_tx_encoder.sv
// tb/tb_gig_basex_tx_encoder.sv - vector-table bench with expected-output scoreboard for gig_basex_tx_encoder
module tb_gig_basex_tx_encoder;
  import gig_basex_tx_encoder_pkg::*;

  typedef struct {
    logic       rst;
    logic       link;
    logic       en;
    logic       er;
    logic [7:0] d;
    logic [7:0] e_data;
    logic       e_ctl;
    logic       e_fneg;
    logic       e_act;
    logic       e_drop;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       ctl;
    logic       fneg;
    logic       act;
    logic       drop;
  } exp_t;

  logic       clk_125mhz;
  logic       rst;
  logic       link_up;
  GmiiBus     gmii_tx_bus;
  logic       tx_data_is_ctl;
  logic [7:0] tx_data;
  logic       tx_force_disparity_negative;
  logic       tx_frame_active;
  logic       tx_frame_dropped;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks;
  int   failures;

  gig_basex_tx_encoder dut (
    .clk_125mhz                  (clk_125mhz),
    .rst                         (rst),
    .link_up                     (link_up),
    .gmii_tx_bus                 (gmii_tx_bus),
    .tx_data_is_ctl              (tx_data_is_ctl),
    .tx_data                     (tx_data),
    .tx_force_disparity_negative (tx_force_disparity_negative),
    .tx_frame_active             (tx_frame_active),
    .tx_frame_dropped            (tx_frame_dropped)
  );

  initial begin
    clk_125mhz = 1'b0;
    forever #4 clk_125mhz = ~clk_125mhz;
  end

  task automatic add(input logic r, input logic l, input logic e, input logic er,
                     input logic [7:0] d, input logic [7:0] ed, input logic ec,
                     input logic ef, input logic ea, input logic edr);
    vec_t v;
    v.rst = r; v.link = l; v.en = e; v.er = er; v.d = d;
    v.e_data = ed; v.e_ctl = ec; v.e_fneg = ef; v.e_act = ea; v.e_drop = edr;
    vecs.push_back(v);
  endtask

  // Idle output expected on an even (K28.5) or odd (D16.2) slot.
  task automatic idl(input logic l, input logic e, input logic [7:0] d,
                     input logic even, input logic drop);
    if (even) add(1'b0, l, e, 1'b0, d, 8'hBC, 1'b1, 1'b1, 1'b0, drop);
    else      add(1'b0, l, e, 1'b0, d, 8'h50, 1'b0, 1'b0, 1'b0, drop);
  endtask

  // In-frame output: data byte (ctl=0) or K char, frame active.
  task automatic frm(input logic l, input logic er, input logic [7:0] d,
                     input logic [7:0] ed, input logic ec);
    add(1'b0, l, 1'b1, er, d, ed, ec, 1'b0, 1'b1, 1'b0);
  endtask

  // End-of-packet K char (/T/ or /R/), frame inactive.
  task automatic eop(input logic e, input logic er, input logic [7:0] ed, input logic drop);
    add(1'b0, 1'b1, e, er, 8'h00, ed, 1'b1, 1'b0, 1'b0, drop);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    link_up  = 1'b1;
    gmii_tx_bus = '0;

    // Reset held 4 cycles.
    repeat (4) add(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hBC, 1'b1, 1'b1, 1'b0, 1'b0);
    // Post-reset idles, first slot odd.
    idl(1, 0, 8'h00, 0, 0); idl(1, 0, 8'h00, 1, 0);
    idl(1, 0, 8'h00, 0, 0); idl(1, 0, 8'h00, 1, 0);
    idl(1, 0, 8'h00, 0, 0);
    // Aligned frame, 11 input bytes; link_up drops mid-frame without effect.
    frm(1, 0, 8'h55, 8'hFB, 1);
    for (int i = 0; i < 6; i++) frm(1, 0, 8'h55, 8'h55, 0);
    frm(1, 0, 8'hD5, 8'hD5, 0);
    frm(0, 0, 8'h11, 8'h11, 0);
    frm(0, 0, 8'h22, 8'h22, 0);
    frm(0, 0, 8'h33, 8'h33, 0);
    eop(0, 0, 8'hFD, 0);
    eop(0, 0, 8'hF7, 0);
    eop(0, 0, 8'hF7, 0);          // odd frame length: second /R/
    idl(1, 0, 8'h00, 1, 0);
    idl(1, 0, 8'h00, 0, 0);
    idl(1, 0, 8'h00, 1, 0);
    // Misaligned start, /V/ on payload byte 2.
    idl(1, 1, 8'h55, 0, 0);       // first byte lost under D16.2
    frm(1, 0, 8'h55, 8'hFB, 1);
    frm(1, 0, 8'h55, 8'h55, 0);
    frm(1, 0, 8'hD5, 8'hD5, 0);
    frm(1, 0, 8'hA1, 8'hA1, 0);
    frm(1, 1, 8'hA2, 8'hFE, 1);
    frm(1, 0, 8'hA3, 8'hA3, 0);
    frm(1, 0, 8'hA4, 8'hA4, 0);
    eop(0, 0, 8'hFD, 0);
    eop(0, 0, 8'hF7, 0);
    eop(0, 0, 8'hF7, 0);
    idl(1, 0, 8'h00, 1, 0);
    idl(1, 0, 8'h00, 0, 0);
    // Even-length frame: single /R/; er with en=0 treated as en=0.
    frm(1, 0, 8'h55, 8'hFB, 1);
    frm(1, 0, 8'hD5, 8'hD5, 0);
    frm(1, 0, 8'h01, 8'h01, 0);
    frm(1, 0, 8'h02, 8'h02, 0);
    eop(0, 1, 8'hFD, 0);
    eop(0, 1, 8'hF7, 0);
    idl(1, 0, 8'h00, 1, 0);
    // Start with link down: dropped, idles until en falls.
    idl(0, 1, 8'h55, 0, 1);
    idl(1, 1, 8'h55, 1, 0);
    idl(1, 1, 8'h55, 0, 0);
    idl(1, 0, 8'h00, 1, 0);
    idl(0, 0, 8'h00, 0, 0);
    // en and link_up rise together: accepted.
    frm(1, 0, 8'h55, 8'hFB, 1);
    frm(1, 0, 8'h66, 8'h66, 0);
    eop(0, 0, 8'hFD, 0);
    eop(0, 0, 8'hF7, 0);
    // en reasserted during /R/: dropped once, idles until en falls.
    add(1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 8'hBC, 1'b1, 1'b1, 1'b0, 1'b1);
    idl(1, 1, 8'h55, 0, 0);
    idl(1, 1, 8'h55, 1, 0);
    idl(1, 0, 8'h00, 0, 0);
    // Next frame is encoded normally.
    frm(1, 0, 8'h77, 8'hFB, 1);
    frm(1, 0, 8'h88, 8'h88, 0);
    eop(0, 0, 8'hFD, 0);
    eop(0, 0, 8'hF7, 0);
    idl(1, 0, 8'h00, 1, 0);
    // Reset mid-frame truncates without /T/; next slot is odd D16.2.
    idl(1, 1, 8'h55, 0, 0);
    frm(1, 0, 8'h55, 8'hFB, 1);
    frm(1, 0, 8'h99, 8'h99, 0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 8'h55, 8'hBC, 1'b1, 1'b1, 1'b0, 1'b0);
    idl(1, 0, 8'h00, 0, 0);
    idl(1, 0, 8'h00, 1, 0);

    @(negedge clk_125mhz);
    for (int i = 0; i < vecs.size(); i++) begin
      exp_t ex;
      exp_t got;
      rst                = vecs[i].rst;
      link_up            = vecs[i].link;
      gmii_tx_bus.en     = vecs[i].en;
      gmii_tx_bus.er     = vecs[i].er;
      gmii_tx_bus.data   = vecs[i].d;
      gmii_tx_bus.dvalid = 1'($urandom_range(0, 1));
      ex.idx  = i;
      ex.data = vecs[i].e_data;
      ex.ctl  = vecs[i].e_ctl;
      ex.fneg = vecs[i].e_fneg;
      ex.act  = vecs[i].e_act;
      ex.drop = vecs[i].e_drop;
      sb.push_back(ex);
      @(posedge clk_125mhz);
      #1;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL vec%0d scoreboard empty", i);
      end else begin
        got = sb.pop_front();
        if ({tx_data, tx_data_is_ctl, tx_force_disparity_negative, tx_frame_active, tx_frame_dropped}
            !== {got.data, got.ctl, got.fneg, got.act, got.drop}) begin
          failures++;
          $display("FAIL vec%0d got data=%02h ctl=%0b fneg=%0b act=%0b drop=%0b want data=%02h ctl=%0b fneg=%0b act=%0b drop=%0b",
                   got.idx, tx_data, tx_data_is_ctl, tx_force_disparity_negative, tx_frame_active,
                   tx_frame_dropped, got.data, got.ctl, got.fneg, got.act, got.drop);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
